// File: rtl/gsim_sched_if.sv
// Handshake and bus bundle between the solver I/O / datapath and the gsim_sched sequencer.
// Latency: none (wires only).
// Backpressure: none; in_en is a one-word-per-cycle strobe with no ready.
//
// Signals:
//   in_en      one b_in word valid this cycle                  (env -> sched)
//   cfg_eps    convergence threshold, unsigned Q16.16          (env -> sched)
//   delta_abs  |x_new - x_old| from datapath, valid on commit  (env -> sched)
//   ld_we/ld_idx             b/ans load write strobe and slot  (sched -> env)
//   upd_idx/upd_stage        variable and pipe stage in flight (sched -> env)
//   upd_commit               write datapath result to ans      (sched -> env)
//   round_cnt/converged/busy solve status                      (sched -> env)
//   rd_idx/out_valid         result read-out address / valid   (sched -> env)
interface gsim_sched_if;
    logic        in_en;
    logic [31:0] cfg_eps;
    logic [31:0] delta_abs;
    logic        ld_we;
    logic [3:0]  ld_idx;
    logic [3:0]  upd_idx;
    logic [2:0]  upd_stage;
    logic        upd_commit;
    logic [6:0]  round_cnt;
    logic        converged;
    logic        busy;
    logic [3:0]  rd_idx;
    logic        out_valid;

    // Environment side (top-level I/O plus datapath).
    modport master (
        output in_en, cfg_eps, delta_abs,
        input  ld_we, ld_idx, upd_idx, upd_stage, upd_commit,
        input  round_cnt, converged, busy, rd_idx, out_valid
    );

    // Sequencer side.
    modport slave (
        input  in_en, cfg_eps, delta_abs,
        output ld_we, ld_idx, upd_idx, upd_stage, upd_commit,
        output round_cnt, converged, busy, rd_idx, out_valid
    );
endinterface

// File: rtl/gsim_sched.sv
// Gauss-Seidel sequencer: b-vector load count, per-variable pipe stepping, round count, early exit, read-out.
// Latency: ld_we/upd_commit combinational from state; out_valid lags rd_idx by 1 cycle.
// Backpressure: none; load advances only on in_en, CALC and SEND run free with no stall.
//
// Ports: clk, reset (sync, active-high), io (gsim_sched_if.slave) carrying in_en, cfg_eps,
// delta_abs in; ld_we, ld_idx, upd_idx, upd_stage, upd_commit, round_cnt, converged, busy,
// rd_idx, out_valid out.
module gsim_sched #(
    parameter int N_VAR     = 16,
    parameter int PIPE_LAT  = 4,
    parameter int MAX_ROUND = 70,
    parameter int MIN_ROUND = 2
) (
    input  logic         clk,
    input  logic         reset,
    gsim_sched_if.slave  io
);

    localparam logic [3:0] LAST_IDX   = 4'(N_VAR - 1);
    localparam logic [2:0] LAST_STAGE = 3'(PIPE_LAT);
    localparam logic [6:0] LAST_ROUND = 7'(MAX_ROUND - 1);
    localparam logic [7:0] MIN_R      = 8'(MIN_ROUND);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_CALC = 2'd1,
        S_SEND = 2'd2
    } state_t;

    state_t      state_q,     state_d;
    logic [3:0]  cnt_q,       cnt_d;
    logic [2:0]  stage_q,     stage_d;
    logic [6:0]  round_q,     round_d;
    logic [31:0] max_delta_q, max_delta_d;
    logic [31:0] eps_q,       eps_d;
    logic        conv_q,      conv_d;
    logic        out_valid_q, out_valid_d;

    logic        in_load;
    logic        in_calc;
    logic        in_send;
    logic        stage_last;
    logic        cnt_last;
    logic [31:0] rmax;
    logic [7:0]  round_next;
    logic        early_ok;

    assign in_load    = (state_q == S_LOAD);
    assign in_calc    = (state_q == S_CALC);
    assign in_send    = (state_q == S_SEND);
    assign stage_last = (stage_q == LAST_STAGE);
    assign cnt_last   = (cnt_q == LAST_IDX);

    // Round maximum including the delta being committed this very cycle, so the
    // last variable of a round is judged within its own round.
    assign rmax       = (io.delta_abs > max_delta_q) ? io.delta_abs : max_delta_q;
    // One bit wider so MIN_ROUND up to 127 compares without wrap.
    assign round_next = {1'b0, round_q} + 8'd1;
    assign early_ok   = (rmax <= eps_q) && (round_next >= MIN_R);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        round_d     = round_q;
        max_delta_d = max_delta_q;
        eps_d       = eps_q;
        conv_d      = conv_q;
        out_valid_d = in_send;

        case (state_q)
            S_LOAD: begin
                if (io.in_en) begin
                    if (cnt_last) begin
                        // Last b word: open a fresh solve and latch the threshold.
                        state_d     = S_CALC;
                        cnt_d       = 4'd0;
                        stage_d     = 3'd0;
                        round_d     = 7'd0;
                        max_delta_d = 32'd0;
                        eps_d       = io.cfg_eps;
                        conv_d      = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end

            S_CALC: begin
                if (stage_last) begin
                    stage_d     = 3'd0;
                    max_delta_d = rmax;
                    if (cnt_last) begin
                        // Round end: round_cnt counts every finished round, exits included.
                        cnt_d       = 4'd0;
                        round_d     = round_next[6:0];
                        max_delta_d = 32'd0;
                        if (early_ok) begin
                            state_d = S_SEND;
                            conv_d  = 1'b1;
                        end else if (round_q == LAST_ROUND) begin
                            state_d = S_SEND;
                            conv_d  = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end else begin
                    stage_d = stage_q + 3'd1;
                end
            end

            S_SEND: begin
                if (cnt_last) begin
                    state_d = S_LOAD;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            default: begin
                state_d = S_LOAD;
                cnt_d   = 4'd0;
                stage_d = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            cnt_q       <= 4'd0;
            stage_q     <= 3'd0;
            round_q     <= 7'd0;
            max_delta_q <= 32'd0;
            eps_q       <= 32'd0;
            conv_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            round_q     <= round_d;
            max_delta_q <= max_delta_d;
            eps_q       <= eps_d;
            conv_q      <= conv_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Write strobes are masked by reset so an abort takes effect in the reset cycle itself.
    assign io.ld_we      = io.in_en & in_load & ~reset;
    assign io.upd_commit = in_calc & stage_last & ~reset;

    // Index outputs are zero outside their own phase.
    assign io.ld_idx     = in_load ? cnt_q   : 4'd0;
    assign io.upd_idx    = in_calc ? cnt_q   : 4'd0;
    assign io.upd_stage  = in_calc ? stage_q : 3'd0;
    assign io.rd_idx     = in_send ? cnt_q   : 4'd0;

    assign io.round_cnt  = round_q;
    assign io.converged  = conv_q;
    assign io.busy       = ~in_load;
    assign io.out_valid  = out_valid_q;

endmodule

// File: tb/tb_gsim_sched.sv
// Self-checking bench for gsim_sched: directed and randomized solves against a round-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_gsim_sched;

    localparam int N_VAR     = 16;
    localparam int PIPE_LAT  = 4;
    localparam int MAX_ROUND = 70;
    localparam int MIN_ROUND = 2;
    localparam int TBL_LEN   = MAX_ROUND * N_VAR;
    localparam int VAR_CYC   = PIPE_LAT + 1;

    logic clk = 1'b0;
    logic reset;

    gsim_sched_if sif ();

    gsim_sched #(
        .N_VAR     (N_VAR),
        .PIPE_LAT  (PIPE_LAT),
        .MAX_ROUND (MAX_ROUND),
        .MIN_ROUND (MIN_ROUND)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (sif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Delta table indexed by commit number within the current solve: entry r*N_VAR+v
    // is what the datapath reports for variable v in round r+1.
    logic [31:0] dtbl [0:TBL_LEN-1];
    int          commit_k = 0;
    int          base_k   = 0;
    int          didx;
    logic [31:0] dval;

    always @(posedge clk) begin
        if (sif.upd_commit) commit_k <= commit_k + 1;
    end

    always_comb begin
        didx = commit_k - base_k;
        dval = 32'd0;
        if (didx >= 0 && didx < TBL_LEN) dval = dtbl[didx[10:0]];
    end
    assign sif.delta_abs = dval;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Round-level model: run rounds until the round maximum is within eps after the
    // minimum round count, or the cap is hit.
    task automatic model(input logic [31:0] eps, output int rounds, output bit conv);
        logic [31:0] rmax;
        rounds = MAX_ROUND;
        conv   = 1'b0;
        for (int r = 1; r <= MAX_ROUND; r++) begin
            rmax = 32'd0;
            for (int v = 0; v < N_VAR; v++)
                if (dtbl[(r-1)*N_VAR + v] > rmax) rmax = dtbl[(r-1)*N_VAR + v];
            if (rmax <= eps && r >= MIN_ROUND) begin
                rounds = r;
                conv   = 1'b1;
                return;
            end
        end
    endtask

    task automatic fill_const(input logic [31:0] val);
        for (int i = 0; i < TBL_LEN; i++) dtbl[i] = val;
    endtask

    // Random solve: rounds before round k carry one out-of-threshold variable (sometimes
    // with the MSB set to catch a signed compare); from round k on all deltas are within eps.
    task automatic fill_random(output logic [31:0] eps);
        int k;
        int hot;
        eps = 32'($urandom_range(0, 1000));
        k   = $urandom_range(1, 6);
        for (int r = 0; r < MAX_ROUND; r++) begin
            hot = $urandom_range(0, N_VAR - 1);
            for (int v = 0; v < N_VAR; v++) begin
                dtbl[r*N_VAR + v] = 32'($urandom_range(0, eps));
                if (r < k - 1 && v == hot) begin
                    if ($urandom_range(0, 1) == 1) dtbl[r*N_VAR + v] = 32'h8000_0000 | 32'($urandom);
                    else dtbl[r*N_VAR + v] = eps + 32'd1 + 32'($urandom_range(0, 5000));
                end
            end
        end
    endtask

    // Load 16 words with random idle gaps. When tail is set the first cycle is the first
    // LOAD cycle after a SEND: the last out_valid and the held status are visible there.
    task automatic load_phase(input logic [31:0] eps, input bit tail, input bit imm,
                              input int prev_r, input bit prev_c);
        int  gap;
        bit  first = 1'b1;
        for (int i = 0; i < N_VAR; i++) begin
            gap = (i == 0 && imm) ? 0 : $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                sif.in_en = 1'b0;
                @(negedge clk);
                chk("ld_we_idle", sif.ld_we, 1'b0);
                chk("busy_load", sif.busy, 1'b0);
                chk("out_valid_load", sif.out_valid, (tail && first) ? 1'b1 : 1'b0);
                if (tail && first) begin
                    chk("round_cnt_held", sif.round_cnt, prev_r);
                    chk("converged_held", sif.converged, prev_c);
                end
                first = 1'b0;
                next_cycle();
            end
            sif.in_en   = 1'b1;
            sif.cfg_eps = eps;
            @(negedge clk);
            chk("ld_we_pulse", sif.ld_we, 1'b1);
            chk("ld_idx", sif.ld_idx, i);
            chk("out_valid_load", sif.out_valid, (tail && first) ? 1'b1 : 1'b0);
            first = 1'b0;
            next_cycle();
        end
        sif.in_en   = 1'b0;
        // Threshold must have been captured at the LOAD->CALC transition.
        sif.cfg_eps = 32'($urandom);
    endtask

    task automatic calc_phase(input int exp_rounds);
        int c = 0;
        int k = 0;
        bit done = 1'b0;
        base_k = commit_k;
        while (!done && c < 6000) begin
            sif.in_en = $urandom_range(0, 1) == 1;
            @(negedge clk);
            if (c == 0) chk("busy_rise", sif.busy, 1'b1);
            chk("ld_we_calc", sif.ld_we, 1'b0);
            chk("upd_commit", sif.upd_commit, (c % VAR_CYC) == PIPE_LAT);
            if (sif.upd_commit) begin
                chk("upd_idx", sif.upd_idx, k % N_VAR);
                k++;
                if (k == exp_rounds * N_VAR) begin
                    chk("calc_len", c + 1, exp_rounds * N_VAR * VAR_CYC);
                    done = 1'b1;
                end
            end
            next_cycle();
            c++;
        end
        sif.in_en = 1'b0;
        if (!done) chk("calc_timeout_commits", k, exp_rounds * N_VAR);
    endtask

    task automatic send_phase(input int exp_rounds, input bit exp_conv);
        for (int j = 0; j < N_VAR; j++) begin
            @(negedge clk);
            if (j == 0) begin
                chk("round_cnt", sif.round_cnt, exp_rounds);
                chk("converged", sif.converged, exp_conv);
            end
            chk("rd_idx", sif.rd_idx, j);
            chk("out_valid_send", sif.out_valid, j > 0);
            chk("commit_in_send", sif.upd_commit, 1'b0);
            chk("busy_send", sif.busy, 1'b1);
            next_cycle();
        end
    endtask

    task automatic do_solve(input logic [31:0] eps, input bit tail, input bit imm,
                            input int prev_r, input bit prev_c,
                            output int r, output bit cv);
        model(eps, r, cv);
        load_phase(eps, tail, imm, prev_r, prev_c);
        calc_phase(r);
        send_phase(r, cv);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ld_we"},      sif.ld_we,      1'b0);
        chk({tag, "_ld_idx"},     sif.ld_idx,     4'd0);
        chk({tag, "_upd_idx"},    sif.upd_idx,    4'd0);
        chk({tag, "_upd_stage"},  sif.upd_stage,  3'd0);
        chk({tag, "_upd_commit"}, sif.upd_commit, 1'b0);
        chk({tag, "_round_cnt"},  sif.round_cnt,  7'd0);
        chk({tag, "_converged"},  sif.converged,  1'b0);
        chk({tag, "_busy"},       sif.busy,       1'b0);
        chk({tag, "_rd_idx"},     sif.rd_idx,     4'd0);
        chk({tag, "_out_valid"},  sif.out_valid,  1'b0);
    endtask

    initial begin
        int          r;
        bit          cv;
        int          pr;
        bit          pc;
        logic [31:0] eps;
        int          target;

        reset       = 1'b1;
        sif.in_en   = 1'b0;
        sif.cfg_eps = 32'd0;
        fill_const(32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("reset");
        next_cycle();

        // Early exit: all deltas zero, eps zero -> exits at the minimum round.
        fill_const(32'd0);
        do_solve(32'd0, 1'b0, 1'b0, 0, 1'b0, r, cv);
        pr = r; pc = cv;

        // Boundary: var 15 at 11 keeps rounds 2 and 3 open; round 4 all equal to eps exits.
        fill_const(32'd10);
        for (int i = 0; i < N_VAR; i++) dtbl[i] = 32'd0;
        for (int rr = 1; rr <= 2; rr++)
            for (int v = 0; v < N_VAR; v++)
                dtbl[rr*N_VAR + v] = (v == N_VAR - 1) ? 32'd11 : 32'd0;
        do_solve(32'd10, 1'b1, 1'b1, pr, pc, r, cv);
        pr = r; pc = cv;

        // Cap: never converges, runs the full round budget.
        fill_const(32'd100);
        do_solve(32'd10, 1'b1, 1'b0, pr, pc, r, cv);
        pr = r; pc = cv;

        // Randomized solves.
        for (int t = 0; t < 3; t++) begin
            fill_random(eps);
            do_solve(eps, 1'b1, $urandom_range(0, 1) == 1, pr, pc, r, cv);
            pr = r; pc = cv;
        end

        // Reset during CALC in round 5, stage 2 of a variable, then a clean re-solve.
        fill_const(32'd100);
        load_phase(32'd10, 1'b1, 1'b0, pr, pc);
        base_k = commit_k;
        target = 4 * N_VAR * VAR_CYC + 7 * VAR_CYC + 2;
        for (int c = 0; c < target; c++) begin
            @(negedge clk);
            chk("pre_reset_commit", sif.upd_commit, (c % VAR_CYC) == PIPE_LAT);
            next_cycle();
        end
        reset = 1'b1;
        @(negedge clk);
        chk("pre_reset_stage", sif.upd_stage, 3'd2);
        chk("pre_reset_round", sif.round_cnt, 7'd4);
        chk("reset_cycle_commit", sif.upd_commit, 1'b0);
        next_cycle();
        reset = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        next_cycle();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk("post_abort_commit", sif.upd_commit, 1'b0);
            chk("post_abort_busy", sif.busy, 1'b0);
            chk("post_abort_out_valid", sif.out_valid, 1'b0);
            next_cycle();
        end
        fill_random(eps);
        do_solve(eps, 1'b0, 1'b0, 0, 1'b0, r, cv);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
